sr_cmd_sequencer: RTL and testbench
===================================

// Module: sr_cmd_sequencer
// PURPOSE
//  Upstream stage of the SR flip-flop. Buffers timed set/reset commands and drives the flip-flop's
//  2-bit sr input one command at a time. Holds each command for a programmed number of cycles,
//  then inserts a hold (2'b00) gap. The illegal code 2'b11 never reaches the flip-flop.
//  Compares the flip-flop's q feedback against the expected value after every set/reset.
// PARAMETERS
//  DEPTH   4  command FIFO entries; power of 2, >=2
//  HOLD_W  4  width of the per-command hold field
//  GAP     1  forced 2'b00 cycles after each command, 0..15 (0 = none)
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       command offered
//  in_ready   out  1       FIFO can accept (= !full)
//  in_op      in   2       00 wait, 01 reset, 10 set, 11 illegal
//  in_hold    in   HOLD_W  command drives sr for in_hold+1 cycles
//  sr         out  2       registered drive to flip-flop sr input
//  q_fb       in   1       flip-flop q, fed back
//  busy       out  1       state!=IDLE or FIFO non-empty
//  cmd_err    out  1       1-cycle pulse: illegal op presented and accepted
//  q_err      out  1       1-cycle pulse: q_fb mismatch after set/reset
// BEHAVIOUR
//  - Reset values (async): sr=00, state IDLE, FIFO empty, busy=0, cmd_err=0, q_err=0, in_ready=1.
//  - Accept: an edge with in_valid && in_ready.
//    - in_op 01/10/00: the command is pushed.
//    - in_op 11: the command is consumed but not stored; cmd_err=1 the following cycle.
//  - Full FIFO: in_ready=0. No push-through when full, even if a pop happens on the same edge.
//  - FSM states: IDLE, DRIVE, GAP.
//    - IDLE: if FIFO non-empty, pop, load cnt=hold, sr<=op, go to DRIVE. Otherwise sr<=00.
//    - DRIVE: sr holds op. cnt decrements each edge. At cnt==0:
//      - sr<=00; go to GAP with gcnt=GAP-1 if GAP>0, otherwise go to IDLE.
//    - GAP: sr=00. At gcnt==0 go to IDLE, otherwise decrement gcnt.
//  - Latency: a command accepted at edge E into an empty FIFO makes sr=op after edge E+1.
//    sr stays op for exactly hold+1 cycles.
//  - Back-to-back: with GAP=0 there is one IDLE cycle (sr=00) between commands.
//  - q check: applies to op 01/10 only. In the first cycle after DRIVE ends (sr back to 00):
//    - compare q_fb with the expected value (10->1, 01->0);
//    - on mismatch, q_err=1 the next cycle.
//    - op 00 is never checked.
//  - Wrap-around: FIFO pointers have log2(DEPTH)+1 bits. Full and empty come from the MSB
//    compare; pointers wrap modulo 2*DEPTH.
//  - Reset mid-operation flushes the FIFO, aborts DRIVE/GAP, forces sr=00 immediately
//    (async), and drops any pending q check.
//  - sr is never 11, by construction: illegal ops never enter the FIFO.
// STRUCTURE
//  - Shared package sr_pkg:
//    - localparams SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILL=2'b11;
//    - FSM state encoding ST_IDLE/ST_DRIVE/ST_GAP.
//  - Sub-module sr_cmd_fifo:
//    - synchronous FIFO, width 2+HOLD_W, depth DEPTH;
//    - async reset; push/pop/full/empty.
//  - Top holds the FSM, counters, sr register, q check and error pulses.
// TESTING
//  1. Reset, then accept set with hold=2, GAP=1 -> sr=10 for 3 cycles starting at E+1,
//     then 00 for 1 cycle; busy drops 1 cycle later.
//  2. Offer op=11 -> cmd_err pulses once; sr stays 00; FIFO count unchanged.
//  3. Push 5 commands with DEPTH=4 while the FSM is stalled on hold=15 ->
//     in_ready=0 after 4 pushes; the 5th is held off; order preserved on drain.
//  4. Set command with q_fb tied 0 -> q_err=1 for exactly one cycle, 2 cycles after DRIVE ends.
//     A reset command with q_fb=0 -> no q_err.
//  5. Assert rst mid-DRIVE with 3 entries queued -> sr=00 during reset, busy=0, FIFO empty;
//     the next accepted command drives normally.
//  6. Alternate pushes/pops across 2*DEPTH+3 commands -> pointer wrap is correct;
//     sr sequence matches the input sequence exactly.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared encodings for the SR command sequencer: flip-flop drive codes and FSM states.
package sr_pkg;

  // Codes driven onto the flip-flop sr input; SR_ILL is never allowed to reach it.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } sr_state_e;

  // Only set and reset leave a known value on q that can be checked afterwards.
  function automatic logic is_checked_op(input logic [1:0] op);
    return (op == SR_SET) || (op == SR_RST);
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small synchronous FIFO for buffered sequencer commands. Pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
module sr_cmd_fifo
  import sr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values; a push into a full FIFO is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer and storage registers, flushed by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Upstream stage of the SR flip-flop: buffers timed commands, drives sr one command
// at a time with a hold gap afterwards, rejects the illegal code and checks q feedback.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [1:0]        sr,
  input  logic              q_fb,
  output logic              busy,
  output logic              cmd_err,
  output logic              q_err
);

  localparam int         CW       = 2 + HOLD_W;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  sr_state_e         state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [1:0]        sr_q, sr_d;
  logic              chk_pend_q, chk_pend_d;
  logic              exp_q_q, exp_q_d;
  logic              q_err_q, q_err_d;
  logic              cmd_err_q, cmd_err_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_rdata;
  logic [1:0]        fifo_op;
  logic [HOLD_W-1:0] fifo_hold;

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_op != SR_ILL);
  assign fifo_op   = fifo_rdata[CW-1:HOLD_W];
  assign fifo_hold = fifo_rdata[HOLD_W-1:0];

  assign sr      = sr_q;
  assign busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign cmd_err = cmd_err_q;
  assign q_err   = q_err_q;

  sr_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(CW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata({in_op, in_hold}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Command FSM: next state, counters, sr drive, q-check scheduling and error pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    sr_d       = sr_q;
    exp_q_d    = exp_q_q;
    chk_pend_d = 1'b0;
    pop        = 1'b0;
    q_err_d    = chk_pend_q && (q_fb != exp_q_q);
    cmd_err_d  = accept && (in_op == SR_ILL);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = fifo_hold;
          sr_d    = fifo_op;
          state_d = ST_DRIVE;
        end else begin
          sr_d = SR_HOLD;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          sr_d       = SR_HOLD;
          chk_pend_d = is_checked_op(sr_q);
          exp_q_d    = (sr_q == SR_SET);
          if (GAP > 0) begin
            state_d = ST_GAP;
            gcnt_d  = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        sr_d = SR_HOLD;
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sr_d    = SR_HOLD;
      end
    endcase
  end

  // State registers; reset aborts any command and drops a pending q check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      sr_q       <= SR_HOLD;
      chk_pend_q <= 1'b0;
      exp_q_q    <= 1'b0;
      q_err_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      sr_q       <= sr_d;
      chk_pend_q <= chk_pend_d;
      exp_q_q    <= exp_q_d;
      q_err_q    <= q_err_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Testbench for sr_cmd_sequencer: directed and random steps checked every cycle against
// a command-level reference model that expands each command into its sr time slots.
module tb_sr_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;
  localparam int GAP    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic [1:0]        inOp;
  logic [HOLD_W-1:0] inHold;
  logic [1:0]        sr;
  logic              qFb;
  logic              busy;
  logic              cmdErr;
  logic              qErr;

  int testsRun  = 0;
  int failCount = 0;
  int qErrSeen  = 0;
  int cmdErrSeen = 0;
  int qMode     = 0;

  typedef struct packed {
    logic [1:0]        op;
    logic [HOLD_W-1:0] hold;
  } cmd_t;

  typedef struct packed {
    logic [1:0] srVal;
    logic       chk;
    logic       chkExp;
  } slot_t;

  cmd_t  fifoQ[$];
  slot_t plan[$];
  logic  idleNow, curChk, curChkExp, checkNow, checkExp, ffQ;
  logic  [1:0] expSr;
  logic  expBusy, expReady, expCmdErr, expQErr;

  sr_cmd_sequencer #(
    .DEPTH (DEPTH),
    .HOLD_W(HOLD_W),
    .GAP   (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_op   (inOp),
    .in_hold (inHold),
    .sr      (sr),
    .q_fb    (qFb),
    .busy    (busy),
    .cmd_err (cmdErr),
    .q_err   (qErr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    fifoQ.delete();
    plan.delete();
    idleNow   = 1'b1;
    curChk    = 1'b0;
    curChkExp = 1'b0;
    checkNow  = 1'b0;
    checkExp  = 1'b0;
    expSr     = 2'b00;
    expBusy   = 1'b0;
    expReady  = 1'b1;
    expCmdErr = 1'b0;
    expQErr   = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs as they were before the edge.
  task automatic modelEdge();
    logic  nQErr, nCmdErr, acceptCmd;
    slot_t s;
    cmd_t  c;
    if (expSr == 2'b10) ffQ = 1'b1;
    else if (expSr == 2'b01) ffQ = 1'b0;
    nQErr     = checkNow && (qFb != checkExp);
    checkNow  = curChk;
    checkExp  = curChkExp;
    nCmdErr   = inValid && (inOp == 2'b11) && (fifoQ.size() < DEPTH);
    acceptCmd = inValid && (inOp != 2'b11) && (fifoQ.size() < DEPTH);
    if (plan.size() > 0) begin
      s         = plan.pop_front();
      expSr     = s.srVal;
      curChk    = s.chk;
      curChkExp = s.chkExp;
      idleNow   = 1'b0;
    end else if (!idleNow || fifoQ.size() == 0) begin
      expSr   = 2'b00;
      curChk  = 1'b0;
      idleNow = 1'b1;
    end else begin
      c = fifoQ.pop_front();
      for (int k = 0; k <= int'(c.hold); k++) begin
        s.srVal  = c.op;
        s.chk    = (k == int'(c.hold)) && (c.op == 2'b01 || c.op == 2'b10);
        s.chkExp = (c.op == 2'b10);
        plan.push_back(s);
      end
      for (int k = 0; k < GAP; k++) begin
        s = '0;
        plan.push_back(s);
      end
      s         = plan.pop_front();
      expSr     = s.srVal;
      curChk    = s.chk;
      curChkExp = s.chkExp;
      idleNow   = 1'b0;
    end
    if (acceptCmd) begin
      c.op   = inOp;
      c.hold = inHold;
      fifoQ.push_back(c);
    end
    expCmdErr = nCmdErr;
    expQErr   = nQErr;
    expBusy   = !idleNow || (fifoQ.size() > 0);
    expReady  = (fifoQ.size() < DEPTH);
  endtask

  task automatic checkOutput(input string tag);
    testsRun++;
    assert (sr === expSr) else begin
      failCount++;
      $error("[TB] FAIL %s.sr observed=%b expected=%b", tag, sr, expSr);
    end
    testsRun++;
    assert (busy === expBusy) else begin
      failCount++;
      $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, busy, expBusy);
    end
    testsRun++;
    assert (inReady === expReady) else begin
      failCount++;
      $error("[TB] FAIL %s.in_ready observed=%b expected=%b", tag, inReady, expReady);
    end
    testsRun++;
    assert (cmdErr === expCmdErr) else begin
      failCount++;
      $error("[TB] FAIL %s.cmd_err observed=%b expected=%b", tag, cmdErr, expCmdErr);
    end
    testsRun++;
    assert (qErr === expQErr) else begin
      failCount++;
      $error("[TB] FAIL %s.q_err observed=%b expected=%b", tag, qErr, expQErr);
    end
  endtask

  // Drive one cycle of inputs, clock it into the DUT and the model, then compare.
  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [HOLD_W-1:0] hold, input string tag);
    inValid = v;
    inOp    = op;
    inHold  = hold;
    if (qMode == 0) qFb = ffQ;
    else if (qMode == 1) qFb = 1'($urandom_range(0, 1));
    else qFb = 1'b0;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
    if (qErr === 1'b1) qErrSeen++;
    if (cmdErr === 1'b1) cmdErrSeen++;
  endtask

  // Hold a command on the input until it is taken, within a cycle budget.
  task automatic offerCmd(input logic [1:0] op, input logic [HOLD_W-1:0] hold,
                          input int maxCycles, input string tag);
    logic taken;
    taken = 1'b0;
    for (int i = 0; i < maxCycles && !taken; i++) begin
      taken = (fifoQ.size() < DEPTH);
      applyStimulus(1'b1, op, hold, tag);
    end
    inValid = 1'b0;
    if (!taken) begin
      testsRun++;
      failCount++;
      $error("[TB] FAIL %s.offer_timeout observed=held expected=accepted", tag);
    end
  endtask

  // Idle until the model says all work and pending pulses are done, then check busy.
  task automatic drain(input int maxCycles, input string tag);
    for (int i = 0; i < maxCycles; i++) begin
      if (!expBusy && !checkNow && !curChk && plan.size() == 0) break;
      applyStimulus(1'b0, 2'b00, '0, tag);
    end
    applyStimulus(1'b0, 2'b00, '0, tag);
    testsRun++;
    assert (busy === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s.drain_busy observed=%b expected=0", tag, busy);
    end
  endtask

  // Assert reset part-way through a cycle and hold it across two edges.
  task automatic midReset(input string tag);
    inValid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, "_async"});
    @(posedge clk);
    #1;
    checkOutput({tag, "_held"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [1:0] t1Sr   [6];
  logic       t1Busy [6];

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inOp    = 2'b00;
    inHold  = '0;
    qFb     = 1'b0;
    ffQ     = 1'b0;
    modelReset();
    t1Sr   = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    t1Busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values.
    #2;
    checkOutput("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_release");

    // Test 1: set with hold=2 gives three set cycles, one gap cycle, then idle.
    applyStimulus(1'b1, 2'b10, 4'd2, "t1_accept");
    testsRun++;
    assert (sr === t1Sr[0] && busy === t1Busy[0]) else begin
      failCount++;
      $error("[TB] FAIL t1_seq0 observed=%b/%b expected=%b/%b", sr, busy, t1Sr[0], t1Busy[0]);
    end
    for (int i = 1; i < 6; i++) begin
      applyStimulus(1'b0, 2'b00, '0, "t1_run");
      testsRun++;
      assert (sr === t1Sr[i] && busy === t1Busy[i]) else begin
        failCount++;
        $error("[TB] FAIL t1_seq%0d observed=%b/%b expected=%b/%b", i, sr, busy, t1Sr[i], t1Busy[i]);
      end
    end
    drain(20, "t1_drain");

    // Test 2: illegal op pulses cmd_err once and stores nothing.
    cmdErrSeen = 0;
    applyStimulus(1'b1, 2'b11, 4'd3, "t2_illegal");
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, '0, "t2_after");
    testsRun++;
    assert (cmdErrSeen === 1) else begin
      failCount++;
      $error("[TB] FAIL t2_cmd_err_pulses observed=%0d expected=1", cmdErrSeen);
    end

    // Test 3: stall on a long command, fill the FIFO, fifth push waits for a pop.
    offerCmd(2'b10, 4'd15, 4, "t3_long");
    applyStimulus(1'b0, 2'b00, '0, "t3_wait");
    offerCmd(2'b01, 4'd1, 4, "t3_p1");
    offerCmd(2'b10, 4'd0, 4, "t3_p2");
    offerCmd(2'b00, 4'd2, 4, "t3_p3");
    offerCmd(2'b01, 4'd0, 4, "t3_p4");
    testsRun++;
    assert (inReady === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL t3_full_ready observed=%b expected=0", inReady);
    end
    offerCmd(2'b10, 4'd1, 40, "t3_p5");
    drain(80, "t3_drain");

    // Test 4: q tied low; a set must flag q_err once, a reset must not.
    qMode    = 2;
    qErrSeen = 0;
    offerCmd(2'b10, 4'd1, 4, "t4_set");
    drain(20, "t4_set_drain");
    testsRun++;
    assert (qErrSeen === 1) else begin
      failCount++;
      $error("[TB] FAIL t4_set_q_err_pulses observed=%0d expected=1", qErrSeen);
    end
    qErrSeen = 0;
    offerCmd(2'b01, 4'd1, 4, "t4_rst");
    drain(20, "t4_rst_drain");
    testsRun++;
    assert (qErrSeen === 0) else begin
      failCount++;
      $error("[TB] FAIL t4_rst_q_err_pulses observed=%0d expected=0", qErrSeen);
    end
    qMode = 0;

    // Test 5: reset mid-DRIVE with three entries queued, then a normal command.
    offerCmd(2'b10, 4'd10, 4, "t5_long");
    offerCmd(2'b01, 4'd2, 4, "t5_q1");
    offerCmd(2'b10, 4'd2, 4, "t5_q2");
    offerCmd(2'b01, 4'd2, 4, "t5_q3");
    applyStimulus(1'b0, 2'b00, '0, "t5_mid");
    midReset("t5_rst");
    testsRun++;
    assert (sr === 2'b00 && busy === 1'b0 && inReady === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL t5_after_rst observed=%b/%b/%b expected=00/0/1", sr, busy, inReady);
    end
    offerCmd(2'b10, 4'd1, 4, "t5_next");
    drain(20, "t5_drain");

    // Test 6: push then drain one command at a time across 2*DEPTH+3 commands.
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      offerCmd(2'($urandom_range(0, 2)), HOLD_W'($urandom_range(0, 2)), 4, "t6_push");
      drain(30, "t6_drain");
    end

    // Random traffic with random q feedback and occasional resets.
    qMode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        midReset("rand_rst");
      end else begin
        applyStimulus(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                      HOLD_W'($urandom_range(0, 3)), "rand");
      end
    end
    qMode = 0;
    drain(100, "rand_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
